systolic_act_skew_feeder: RTL
=============================

# systolic_act_skew_feeder

Input-side feeder for the weight-stationary systolic PE array. It accepts one PE_ARRAY_H-wide activation vector per cycle over a valid/ready handshake and drives the array's left-edge activation inputs with the diagonal skew the mesh needs: row i is delayed by i cycles relative to row 0. Upstream bubbles become zero activations. After the last vector of a tile, it drains the skew pipeline and pulses done.

## Interface
- PE_ARRAY_H, 4, number of array rows (activation lanes); ≥1
- IN_DATA_WIDTH, 8, activation width; matches the array's left-data width
- clk  in  1  single clock, rising edge
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- i_vld  in  1  input vector valid
- o_rdy  out  1  feeder can accept a vector this cycle
- i_data  in  [IN_DATA_WIDTH-1:0] x [0:PE_ARRAY_H-1]  activation vector, lane i feeds row i
- i_last  in  1  qualifies the final vector of a tile; sampled only on handshake
- o_left_data  out  [IN_DATA_WIDTH-1:0] x [0:PE_ARRAY_H-1]  skewed activations to the array's left edge
- o_row_vld  out  1 x [0:PE_ARRAY_H-1]  row i carries a real (non-bubble) activation this cycle
- o_busy  out  1  state ≠ IDLE
- o_done  out  1  one-cycle pulse when the last vector's row PE_ARRAY_H-1 element is on o_left_data

## Operation
- Handshake: a vector is accepted in a cycle with i_vld && o_rdy. o_rdy = 1 in IDLE and STREAM, 0 in DRAIN; it is a pure function of state.
- States:
  - IDLE → STREAM on an accept with i_last=0.
  - IDLE or STREAM → DRAIN on an accept with i_last=1.
  - STREAM stays in STREAM on non-last accepts or bubbles.
  - DRAIN → IDLE after PE_ARRAY_H cycles.
- Skew: row i has a shift register of i+1 stages. Stage 0 captures i_data[i] and a valid bit (= accept) every cycle. Every stage shifts every cycle; there is no stall, because the array has no stall.
- Bubble (no accept, any state): stage 0 loads data 0, valid 0. o_left_data[i] is therefore 0 whenever o_row_vld[i] = 0.
- Drain counter: width $clog2(PE_ARRAY_H+1). Cleared on entry to DRAIN; increments each DRAIN cycle. o_done = (state==DRAIN) && (cnt==PE_ARRAY_H-1); that same cycle transitions to IDLE.
- No arithmetic: data passes through bit-exact. Only widths PE_ARRAY_H and IN_DATA_WIDTH are involved.
- Reset, asserted at any time including mid-STREAM or mid-DRAIN:
  - all shift stages, valid bits and the counter clear to 0; state → IDLE;
  - in-flight vectors are discarded and no o_done is issued for them.
- i_last on a bubble cycle is ignored.

## Timing
- Reset values: o_left_data = 0 on all rows, o_row_vld = 0, o_busy = 0, o_done = 0, o_rdy = 1.
- Latency: a vector accepted in cycle t appears on row i in cycle t+1+i. Row 0 is registered (1 cycle); row PE_ARRAY_H-1 arrives at t+PE_ARRAY_H.
- Throughput: one vector per cycle in STREAM.
- Drain: for a last vector accepted at t, DRAIN occupies cycles t+1 … t+PE_ARRAY_H, and o_rdy = 0 for exactly those cycles. o_done is high in cycle t+PE_ARRAY_H. o_rdy = 1 again at t+PE_ARRAY_H+1.
- PE_ARRAY_H = 1: no skew; DRAIN lasts one cycle; o_done is coincident with row 0 valid.
- Back-to-back tiles: a new first vector can be accepted in cycle t+PE_ARRAY_H+1.
- All outputs are registered except o_rdy and o_busy, which are decoded from the state register.

## Structure
- utils_pkg holds:
  - typedef enum logic [1:0] {FEED_IDLE, FEED_STREAM, FEED_DRAIN} feed_state_t;
  - a localparam helper for the counter width.
- Sub-module act_delay_line (params DEPTH, WIDTH): a valid+data shift register with async active-low clear. It is instantiated once per row with DEPTH = i+1 in a generate loop.
- The top level contains the FSM, the drain counter, the handshake, and the row generate loop.

## Test plan
All scenarios use PE_ARRAY_H=4 and IN_DATA_WIDTH=8.
- Single vector {1,2,3,4} with i_last=1 at cycle 0:
  - o_left_data[0]=1 @1, [1]=2 @2, [2]=3 @3, [3]=4 @4;
  - o_done @4; o_rdy=0 for cycles 1–4.
- Three back-to-back vectors {10+k,20+k,30+k,40+k}, k=0..2, last on k=2:
  - row i shows 10(i+1)+k at cycle 1+i+k;
  - o_done @6;
  - all other row outputs are 0 with o_row_vld=0.
- Bubble insertion: i_vld pattern 1,0,1 with data 5,x,7, last on the third:
  - row 0 shows 5,0,7 @1..3 with o_row_vld 1,0,1;
  - row 3 shows 5,0,7 @4..6;
  - the x value never appears on any output.
- Ready honoured: hold i_vld=1 with a changing i_data through DRAIN:
  - no accepts while o_rdy=0;
  - the first post-drain vector is accepted @5 and appears on row 0 @6.
- Reset mid-DRAIN (rst=0 at cycle 2 of scenario 1):
  - all outputs are 0 immediately (asynchronous);
  - no o_done is ever issued for that tile;
  - o_rdy=1 after release.
- PE_ARRAY_H=1 build: vector {9} with i_last → o_left_data[0]=9, o_row_vld[0]=1 and o_done=1, all @1.

Source files
------------

// File: rtl/utils_pkg.sv
// Shared types and helpers for the systolic activation feeder.
// Holds the feeder FSM encoding and the drain-counter width helper.
package utils_pkg;

    typedef enum logic [1:0] {
        FEED_IDLE,
        FEED_STREAM,
        FEED_DRAIN
    } feed_state_t;

    // Counter must hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/systolic_act_skew_feeder_delay.sv
// Valid+data shift register used to skew one activation row.
// Bubbles enter as zero data so downstream never sees stale values.
module act_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vld,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            vld_q[0]  <= i_vld;
            data_q[0] <= i_vld ? i_data : '0;
            for (int k = 1; k < DEPTH; k++) begin
                vld_q[k]  <= vld_q[k-1];
                data_q[k] <= data_q[k-1];
            end
        end
    end

    assign o_vld  = vld_q[DEPTH-1];
    assign o_data = data_q[DEPTH-1];

endmodule

// File: rtl/systolic_act_skew_feeder.sv
// Left-edge activation feeder for the weight-stationary PE array.
// Skews row i by i cycles and drains the skew after a tile's last vector.
module systolic_act_skew_feeder
    import utils_pkg::*;
#(
    parameter int PE_ARRAY_H    = 4,
    parameter int IN_DATA_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_vld,
    output logic                     o_rdy,
    input  logic [IN_DATA_WIDTH-1:0] i_data      [PE_ARRAY_H],
    input  logic                     i_last,
    output logic [IN_DATA_WIDTH-1:0] o_left_data [PE_ARRAY_H],
    output logic [PE_ARRAY_H-1:0]    o_row_vld,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int CNT_W = cnt_width(PE_ARRAY_H);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PE_ARRAY_H - 1);

    feed_state_t      state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             done_q, done_next;
    logic             accept;

    assign o_rdy  = (state != FEED_DRAIN);
    assign o_busy = (state != FEED_IDLE);
    assign o_done = done_q;
    assign accept = i_vld && o_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= FEED_IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            done_q <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            FEED_IDLE, FEED_STREAM: begin
                if (accept) begin
                    if (i_last) begin
                        state_next = FEED_DRAIN;
                        cnt_next   = '0;
                    end else begin
                        state_next = FEED_STREAM;
                    end
                end
            end
            FEED_DRAIN: begin
                cnt_next = cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    state_next = FEED_IDLE;
                end
            end
            default: begin
                state_next = FEED_IDLE;
                cnt_next   = '0;
            end
        endcase
        // Registered so done lines up with the last row's element.
        done_next = (state_next == FEED_DRAIN) && (cnt_next == CNT_LAST);
    end

    for (genvar r = 0; r < PE_ARRAY_H; r++) begin : g_row
        act_delay_line #(
            .DEPTH(r + 1),
            .WIDTH(IN_DATA_WIDTH)
        ) u_line (
            .clk    (clk),
            .rst    (rst),
            .i_vld  (accept),
            .i_data (i_data[r]),
            .o_vld  (o_row_vld[r]),
            .o_data (o_left_data[r])
        );
    end

endmodule
